// File: rtl/multi_gray_bus_synchronizer.sv
// Multi-channel gray-code bus synchronizer.
//
// Brings CHANNEL_COUNT independent gray-coded buses (async FIFO pointers, slow counters) into the
// clk domain. Each channel runs an STAGE_COUNT-flop synchronizer chain followed by a stability
// filter. The filter only passes a value once it has been seen on the chain output for
// STABLE_CYCLES consecutive edges.
//
// Ports:
//   clk               destination clock
//   reset             asynchronous, active-high reset
//   asynchronous_data source-domain gray buses, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   error_clear       per-channel synchronous clear of gray_error
//   synchronous_data  filtered gray value per channel (registered)
//   binary_data       binary equivalent of synchronous_data (registered, same edge)
//   data_changed      one-cycle pulse after a channel's output updates
//   gray_error        sticky flag: an accepted update changed more than one bit
module multi_gray_bus_synchronizer #(
  parameter int unsigned STAGE_COUNT   = 2,
  parameter int unsigned BUS_WIDTH     = 4,
  parameter int unsigned CHANNEL_COUNT = 2,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
  input  logic [CHANNEL_COUNT-1:0]           error_clear,
  output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] synchronous_data,
  output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] binary_data,
  output logic [CHANNEL_COUNT-1:0]           data_changed,
  output logic [CHANNEL_COUNT-1:0]           gray_error
);

  localparam int unsigned CntWidth = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(STABLE_CYCLES);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_chan
    logic [BUS_WIDTH-1:0] stage_q [STAGE_COUNT];
    logic [BUS_WIDTH-1:0] sync_out;
    logic [BUS_WIDTH-1:0] cand_q, cand_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] out_q;
    logic [BUS_WIDTH-1:0] bin_q, bin_d;
    logic                 changed_q;
    logic                 error_q, error_d;
    logic                 accept;

    // Plain flop chain: no logic between stages so each bit resolves metastability on its own.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGE_COUNT; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH];
        for (int i = 1; i < STAGE_COUNT; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign sync_out = stage_q[STAGE_COUNT-1];

    always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      error_d = error_q;
      bin_d   = '0;

      // Run-length of the current sync_out value, saturating at STABLE_CYCLES.
      if (sync_out == cand_q) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end else begin
        cand_d = sync_out;
        cnt_d  = CntOne;
      end

      // Accept on the edge where the run reaches its target length; with STABLE_CYCLES = 1 this
      // is the edge the new value first appears, making the filter transparent.
      accept = (cnt_d == CntMax) && (cand_d != out_q);

      // Binary bit i is the XOR of gray bits i and above.
      for (int i = 0; i < BUS_WIDTH; i++) begin
        bin_d[i] = ^(cand_d >> i);
      end

      // A set on the accepting edge takes priority over a simultaneous clear.
      if (accept && ($countones(cand_d ^ out_q) > 1)) begin
        error_d = 1'b1;
      end else if (error_clear[c]) begin
        error_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cand_q    <= '0;
        cnt_q     <= '0;
        out_q     <= '0;
        bin_q     <= '0;
        changed_q <= 1'b0;
        error_q   <= 1'b0;
      end else begin
        cand_q    <= cand_d;
        cnt_q     <= cnt_d;
        changed_q <= accept;
        error_q   <= error_d;
        if (accept) begin
          out_q <= cand_d;
          bin_q <= bin_d;
        end
      end
    end

    assign synchronous_data[c*BUS_WIDTH +: BUS_WIDTH] = out_q;
    assign binary_data[c*BUS_WIDTH +: BUS_WIDTH]      = bin_q;
    assign data_changed[c]                            = changed_q;
    assign gray_error[c]                              = error_q;
  end

endmodule

// File: tb/tb_multi_gray_bus_synchronizer.sv
module tb_multi_gray_bus_synchronizer;

  localparam int ST = 2;
  localparam int W  = 4;
  localparam int CH = 2;
  localparam int SC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH*W-1:0] asynchronous_data = '0;
  logic [CH-1:0]   error_clear = '0;
  logic [CH*W-1:0] synchronous_data;
  logic [CH*W-1:0] binary_data;
  logic [CH-1:0]   data_changed;
  logic [CH-1:0]   gray_error;

  multi_gray_bus_synchronizer #(
    .STAGE_COUNT  (ST),
    .BUS_WIDTH    (W),
    .CHANNEL_COUNT(CH),
    .STABLE_CYCLES(SC)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .asynchronous_data(asynchronous_data),
    .error_clear      (error_clear),
    .synchronous_data (synchronous_data),
    .binary_data      (binary_data),
    .data_changed     (data_changed),
    .gray_error       (gray_error)
  );

  always #6 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit sb_en    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] to_gray(input int n);
    logic [W-1:0] v;
    v = W'(n);
    return v ^ (v >> 1);
  endfunction

  // Binary value = position of the code in the gray sequence.
  function automatic logic [W-1:0] gray_index(input logic [W-1:0] g);
    for (int n = 0; n < (1 << W); n++) if (to_gray(n) == g) return W'(n);
    return '0;
  endfunction

  function automatic int bits_changed(input logic [W-1:0] a, input logic [W-1:0] b);
    int d = 0;
    for (int i = 0; i < W; i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  // Reference model: a fixed delay line, then a window of the last SC delayed samples.
  logic [W-1:0] m_pipe [CH][$];
  logic [W-1:0] m_win  [CH][$];
  logic [W-1:0] m_out  [CH];
  bit           m_chg  [CH];
  bit           m_err  [CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pipe[c].delete();
      for (int i = 0; i < ST; i++) m_pipe[c].push_back('0);
      m_win[c].delete();
      m_out[c] = '0;
      m_chg[c] = 1'b0;
      m_err[c] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    logic [W-1:0] s;
    bit steady, acc;
    for (int c = 0; c < CH; c++) begin
      s = m_pipe[c].pop_front();
      m_pipe[c].push_back(asynchronous_data[c*W +: W]);
      m_win[c].push_back(s);
      if (m_win[c].size() > SC) m_win[c].delete(0);
      steady = (m_win[c].size() == SC);
      for (int i = 0; i < m_win[c].size(); i++) if (m_win[c][i] != s) steady = 1'b0;
      acc = steady && (s != m_out[c]);
      if (acc && bits_changed(s, m_out[c]) > 1) m_err[c] = 1'b1;
      else if (error_clear[c]) m_err[c] = 1'b0;
      if (acc) m_out[c] = s;
      m_chg[c] = acc;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (sb_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("sb_sync%0d", c), 32'(synchronous_data[c*W +: W]), 32'(m_out[c]));
        check($sformatf("sb_bin%0d", c), 32'(binary_data[c*W +: W]), 32'(gray_index(m_out[c])));
        check($sformatf("sb_chg%0d", c), 32'(data_changed[c]), 32'(m_chg[c]));
        check($sformatf("sb_err%0d", c), 32'(gray_error[c]), 32'(m_err[c]));
      end
    end
  end

  // Pulse log: counts and the output values present during each data_changed pulse.
  int           pulse_cnt [CH];
  logic [W-1:0] log_gray  [CH][$];
  logic [W-1:0] log_bin   [CH][$];

  initial for (int c = 0; c < CH; c++) pulse_cnt[c] = 0;

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (data_changed[c] === 1'b1) begin
        pulse_cnt[c]++;
        log_gray[c].push_back(synchronous_data[c*W +: W]);
        log_bin[c].push_back(binary_data[c*W +: W]);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, base, lat;
    int hold [CH];
    int idx  [CH];

    cycles(2);
    reset = 1'b0;
    sb_en = 1'b1;

    // Reset asserted mid-cycle with nonzero state clears everything at once.
    asynchronous_data = {4'b0011, 4'b0001};
    cycles(8);
    #1 reset = 1'b1;
    #1;
    check("rst_sync", 32'(synchronous_data), 32'h0);
    check("rst_bin", 32'(binary_data), 32'h0);
    check("rst_chg", 32'(data_changed), 32'h0);
    check("rst_err", 32'(gray_error), 32'h0);
    #1;
    asynchronous_data = '0;
    reset = 1'b0;
    p0 = pulse_cnt[0];
    p1 = pulse_cnt[1];
    cycles(20);
    check("idle_pulses", 32'((pulse_cnt[0] - p0) + (pulse_cnt[1] - p1)), 32'd0);

    // Gray sweep on ch0, source step every 30 ns.
    @(negedge clk);
    #1;
    p0 = pulse_cnt[0];
    base = log_bin[0].size();
    for (int k = 1; k <= 16; k++) begin
      asynchronous_data[3:0] = to_gray(k % 16);
      #30;
    end
    cycles(6);
    check("sweep_pulses", 32'(pulse_cnt[0] - p0), 32'd16);
    for (int j = 0; j < 16; j++) begin
      if (base + j < log_bin[0].size())
        check($sformatf("sweep_bin%0d", j), 32'(log_bin[0][base + j]), 32'((j + 1) % 16));
    end
    check("sweep_err", 32'(gray_error[0]), 32'd0);

    // Glitch on ch1: one-clock value is rejected; two-clock value is accepted.
    p1 = pulse_cnt[1];
    asynchronous_data[7:4] = 4'b0001;
    cycles(1);
    asynchronous_data[7:4] = 4'b0000;
    cycles(8);
    check("glitch_pulses", 32'(pulse_cnt[1] - p1), 32'd0);
    check("glitch_sync", 32'(synchronous_data[7:4]), 32'h0);
    base = log_gray[1].size();
    asynchronous_data[7:4] = 4'b0001;
    cycles(2);
    asynchronous_data[7:4] = 4'b0000;
    cycles(8);
    check("hold2_pulses", 32'(pulse_cnt[1] - p1), 32'd2);
    if (log_gray[1].size() > base) check("hold2_value", 32'(log_gray[1][base]), 32'h1);

    // Multi-bit jump on ch0 and the sticky error flag.
    asynchronous_data[3:0] = 4'b0011;
    cycles(6);
    check("jump_sync", 32'(synchronous_data[3:0]), 32'h3);
    check("jump_bin", 32'(binary_data[3:0]), 32'h2);
    check("jump_err", 32'(gray_error[0]), 32'd1);
    cycles(5);
    check("jump_err_sticky", 32'(gray_error[0]), 32'd1);
    error_clear[0] = 1'b1;
    cycles(1);
    error_clear[0] = 1'b0;
    check("err_cleared", 32'(gray_error[0]), 32'd0);
    asynchronous_data[3:0] = 4'b0000;
    cycles(6);
    error_clear[0] = 1'b1;
    cycles(1);
    error_clear[0] = 1'b0;
    check("err_cleared2", 32'(gray_error[0]), 32'd0);
    // Clear held on the accepting edge: the set must win.
    asynchronous_data[3:0] = 4'b0011;
    cycles(3);
    error_clear[0] = 1'b1;
    cycles(1);
    error_clear[0] = 1'b0;
    check("set_wins_chg", 32'(data_changed[0]), 32'd1);
    check("set_wins_sync", 32'(synchronous_data[3:0]), 32'h3);
    check("set_wins_err", 32'(gray_error[0]), 32'd1);

    // Independence: ch1 holds 0110 while ch0 sweeps.
    asynchronous_data[7:4] = 4'b0110;
    cycles(8);
    check("indep_init", 32'(synchronous_data[7:4]), 32'h6);
    p1 = pulse_cnt[1];
    @(negedge clk);
    #1;
    for (int k = 3; k <= 18; k++) begin
      asynchronous_data[3:0] = to_gray(k % 16);
      #30;
    end
    cycles(6);
    check("indep_pulses", 32'(pulse_cnt[1] - p1), 32'd0);
    check("indep_sync", 32'(synchronous_data[7:4]), 32'h6);
    check("indep_err", 32'(gray_error[1]), 32'd1);

    // Reset while ch0's filter holds a candidate with a run of one.
    asynchronous_data = '0;
    cycles(8);
    asynchronous_data[3:0] = 4'b0001;
    cycles(3);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_sync", 32'(synchronous_data), 32'h0);
    check("mid_rst_err", 32'(gray_error), 32'h0);
    #1 reset = 1'b0;
    lat = -1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (synchronous_data[3:0] == 4'b0001) begin
        lat = e;
        break;
      end
    end
    check("mid_rst_latency", 32'(lat), 32'(ST + SC));
    check("mid_rst_err_after", 32'(gray_error[0]), 32'd0);

    // Randomized walk: gray steps, short glitches, arbitrary jumps, random clears.
    cycles(1);
    for (int c = 0; c < CH; c++) begin
      hold[c] = 0;
      idx[c]  = int'(gray_index(asynchronous_data[c*W +: W]));
    end
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2: idx[c] = (idx[c] + 1) % 16;
            3, 4, 5: idx[c] = (idx[c] + 15) % 16;
            6, 7:    idx[c] = idx[c];
            default: idx[c] = int'($urandom_range(0, 15));
          endcase
          asynchronous_data[c*W +: W] = to_gray(idx[c]);
          hold[c] = int'($urandom_range(1, 4));
        end
        hold[c]--;
      end
      error_clear = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      cycles(1);
    end
    error_clear = '0;
    cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_gray_bus_synchronizer.md
Name: multi_gray_bus_synchronizer

Overview:
- Multi-channel, parametrised successor to the single-bus 2-flop synchronizer.
- Brings CHANNEL_COUNT independent gray-coded buses into the destination clock domain. Typical sources are async FIFO pointers and slow-domain counters.
- Each channel has an N-stage flop chain, then a stability filter that rejects sync-output values held for fewer than STABLE_CYCLES edges.
- Per channel it provides registered gray and binary outputs, a change pulse and a sticky gray-code-violation flag.

Parameters:
- STAGE_COUNT, 2, flops in each synchronizer chain; must be >= 2.
- BUS_WIDTH, 4, bits per channel; must be >= 1.
- CHANNEL_COUNT, 2, number of independent channels; must be >= 1.
- STABLE_CYCLES, 2, consecutive equal samples needed before the output updates; must be >= 1.

Ports:
- clk  input  1  destination clock.
- reset  input  1  asynchronous, active-high reset.
- asynchronous_data  input  CHANNEL_COUNT*BUS_WIDTH  source-domain gray buses. Channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- error_clear  input  CHANNEL_COUNT  synchronous, per-channel clear of gray_error.
- synchronous_data  output  CHANNEL_COUNT*BUS_WIDTH  filtered gray value per channel.
- binary_data  output  CHANNEL_COUNT*BUS_WIDTH  gray-to-binary conversion of synchronous_data.
- data_changed  output  CHANNEL_COUNT  one-cycle pulse when a channel's output updates.
- gray_error  output  CHANNEL_COUNT  sticky flag: an accepted update changed more than one bit.

Behaviour:
- Reset (async, active-high):
  - All sync stages, filter registers and counters clear immediately, without a clock edge.
  - synchronous_data, binary_data, data_changed and gray_error all go to 0.
  - Reset asserted mid-filter discards any pending candidate.
- Sync chain:
  - Per channel, STAGE_COUNT flops on clk; no logic between stages.
  - sync_out is the last stage.
- Stability filter, per channel:
  - Holds a candidate register and a saturating counter of width clog2(STABLE_CYCLES+1).
  - Each edge: if sync_out == candidate, counter increments, saturating at STABLE_CYCLES. Otherwise candidate <= sync_out and counter <= 1.
  - Accept when candidate has been sampled at STABLE_CYCLES consecutive edges and differs from synchronous_data. synchronous_data <= candidate on that same edge.
  - Counter saturating at STABLE_CYCLES while candidate == synchronous_data produces no update and no pulse.
- Latency:
  - Input stable before edge k is reflected on synchronous_data after edge k + STAGE_COUNT + STABLE_CYCLES - 1.
  - With defaults, that is 3 edges after the first capturing edge, i.e. 4 edges from the input change.
- Glitch rejection: a sync_out value held for fewer than STABLE_CYCLES edges never reaches the output.
  - With STABLE_CYCLES = 1 the filter is transparent: latency is STAGE_COUNT + 1 register stages.
- binary_data:
  - Updates on the same edge as synchronous_data; both are registered.
  - b[W-1] = g[W-1]; b[i] = b[i+1] XOR g[i].
- data_changed:
  - High for exactly the one cycle following an accepting edge, otherwise low.
  - Back-to-back accepts are possible only when STABLE_CYCLES = 1; each accept produces its own pulse.
- gray_error:
  - Set on an accepting edge when the Hamming distance between the old and new synchronous_data is greater than 1.
  - Cleared on an edge where error_clear[c] = 1.
  - If set and clear occur on the same edge, set wins.
  - The first update after reset is also checked, using 0 as the old value.
- Channel independence: channels share only clk and reset; no cross-channel state or timing coupling.
- Wrap-around: a gray step from the top code back to 0 (e.g. 1000 -> 0000 for W = 4) is a legal 1-bit change and does not set gray_error.

Test Plan:
- Reset:
  - Assert reset mid-cycle with nonzero inputs → all outputs 0 immediately.
  - Release with inputs 0 → no data_changed for 20 cycles.
- Gray sweep, ch0, defaults, clk period 12 ns, source step every 30 ns, 4-bit gray 0000..1000 then back to 0000:
  - Each code appears on synchronous_data exactly 4 edges after the change.
  - binary_data counts 0..15 then 0.
  - 16 data_changed pulses.
  - gray_error = 0.
- Glitch: ch1 driven to 0001 for 1 clk, then back to 0000 → no output change, no pulse. Same value held 2 clks → accepted, one pulse.
- Multi-bit jump: ch0 0000 → 0011, held → synchronous_data = 0011, binary_data = 0010, gray_error[0] = 1 and stays 1.
  - Pulse error_clear[0] → gray_error[0] = 0.
  - Repeat the jump with error_clear[0] asserted on the accepting edge → gray_error[0] = 1.
- Independence: ch0 sweeps while ch1 holds 0110 → ch1 outputs and flags never change.
- Mid-operation reset: ch0 = 0001 with filter counter at 1; pulse reset → outputs 0 at once. After release, 0001 reappears after STAGE_COUNT + STABLE_CYCLES edges, with gray_error = 0.
